sr_ff_monitor: RTL and testbench
================================

# sr_ff_monitor

- Passive, clocked checker that sits on the S/R/Q/QBar interface of an SR flip-flop.
- Samples the S and R drive each rising edge and builds a reference model of the flop's next state.
- Compares the flop's Q/QBar against that model one cycle later, and flags forbidden S=R=1 drive.
- Counts set, reset and illegal events; used alongside the SR flop in benches and on-chip as a health monitor.

## Interface
- CNT_W, 8, width of each event counter (≥2)
- clk  input  1  rising-edge clock, same clock as the monitored flop
- rst_n  input  1  asynchronous, active-low reset
- S  input  1  set drive observed at the flop
- R  input  1  reset drive observed at the flop
- Q  input  1  flop output
- QBar  input  1  flop complementary output
- exp_q  output  1  model's expected Q
- exp_valid  output  1  exp_q is defined (state TRACK)
- mismatch  output  1  one-cycle pulse: Q≠exp_q, or QBar≠~Q, while checked
- illegal  output  1  one-cycle pulse: S=R=1 sampled on previous edge
- set_cnt  output  CNT_W  count of sampled S=1,R=0
- reset_cnt  output  CNT_W  count of sampled S=0,R=1
- illegal_cnt  output  CNT_W  count of sampled S=1,R=1
- err_sticky  output  1  latched error flag (see Configuration)

## Operation
- FSM states: UNKNOWN, TRACK, UNDEF.
  - UNKNOWN: entered on reset. Q is not yet known.
  - TRACK: exp_q is defined.
  - UNDEF: entered after a forbidden S=R=1 drive.
- Transitions on each rising clk, using the sampled {S,R}:
  - 10 → TRACK, exp_q=1, from any state.
  - 01 → TRACK, exp_q=0, from any state.
  - 00: TRACK holds exp_q; UNKNOWN and UNDEF stay in place.
  - 11 → UNDEF from any state. exp_q holds its last value but is not checked.
- Check, performed every edge:
  - If the state was TRACK at the previous edge and the sampled input was not 11, compare the current Q against exp_q as updated at the previous edge.
  - Whenever the previous state was TRACK, also check QBar == ~Q.
  - Any failure → mismatch=1 for exactly one cycle.
- Counters:
  - Increment on the edge that samples the matching {S,R}.
  - Saturate at 2^CNT_W−1; never wrap.
  - 00 increments no counter.
- X/Z on S or R is treated as 11 (illegal).

## Timing
- Reset (rst_n=0, asynchronous):
  - state=UNKNOWN, exp_q=0, exp_valid=0, mismatch=0, illegal=0.
  - All counters 0; err_sticky=0.
- Release is synchronous to the first rising clk with rst_n=1. The first sample is taken on that edge.
- Latency:
  - exp_q and exp_valid update 1 cycle after the edge that samples {S,R}.
  - illegal and mismatch pulse 1 cycle after the offending sample.
  - Counters update 1 cycle after the sample.
- The flop updates Q on edge k from {S,R}@k. The monitor checks that Q on edge k+1 against exp_q built from {S,R}@k.
- Back-to-back illegal drives:
  - illegal stays high continuously.
  - illegal_cnt increments every cycle until saturation.
- 11 followed by 10 or 01: TRACK is re-entered on that edge. The check resumes on the following edge.
- Reset asserted mid-run clears everything immediately, including an in-flight mismatch pulse.

## Configuration
- Macro: SR_MON_STICKY_EN.
- Defined: err_sticky sets on any mismatch or illegal pulse and holds until rst_n=0.
- Undefined: the sticky register is not built, and err_sticky is tied to 0.
- Pulses and counters are identical in both builds.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles, then S=R=0 for 5 cycles.
  - exp_valid=0 and all counters 0 throughout.
  - No mismatch or illegal pulse.
- Set then reset against a correct flop: drive 10, 00, 01, 00.
  - exp_q goes 1, 1, 0, 0 (each one cycle after its sample).
  - set_cnt=1, reset_cnt=1, mismatch never asserts.
- Forbidden drive: drive 11, 11, 10.
  - illegal high for 2 cycles; illegal_cnt=2.
  - exp_valid low after the first 11, high again 1 cycle after the 10.
  - err_sticky=1 with the macro, 0 without.
- Faulty flop: force Q=0 after a 10 drive.
  - mismatch=1 for exactly 1 cycle at the check edge.
  - Force QBar=Q in TRACK: mismatch=1 on the next edge.
- Saturation: CNT_W=2, drive 10 for 6 cycles → set_cnt ends at 3, not 2.
- Async reset mid-run: assert rst_n=0 between edges while err_sticky=1 and the counters are non-zero.
  - All outputs are 0 before the next clk edge.

Source files
------------

// File: rtl/sr_ff_monitor_if.sv
// sr_ff_monitor_if: S/R drive and Q/QBar outputs of a monitored SR flip-flop.
// The master side drives the flop signals (the flop or a bench).
// The slave side only observes them (the monitor).
interface sr_ff_monitor_if;
    logic S;
    logic R;
    logic Q;
    logic QBar;

    modport master (output S, output R, output Q, output QBar);
    modport slave  (input  S, input  R, input  Q, input  QBar);
endinterface

// File: rtl/sr_ff_monitor.sv
// sr_ff_monitor: passive checker for an SR flip-flop.
// It builds a reference model of the flop's next state from the sampled {S,R}.
// One edge later it checks Q/QBar against that model, flags S=R=1 drive, and
// keeps saturating event counters.
// Optional build macro SR_MON_STICKY_EN adds a latched error flag on err_sticky.
// Without the macro, err_sticky is tied to 0.
module sr_ff_monitor #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sr_ff_monitor_if.slave    mon,
    output logic              exp_q,
    output logic              exp_valid,
    output logic              mismatch,
    output logic              illegal,
    output logic [CNT_W-1:0]  set_cnt,
    output logic [CNT_W-1:0]  reset_cnt,
    output logic [CNT_W-1:0]  illegal_cnt,
    output logic              err_sticky
);

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        TRACK   = 2'd1,
        UNDEF   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             exp_q_q, exp_q_d;
    logic             mismatch_q, mismatch_d;
    logic             illegal_q;
    logic             is_set, is_rst, is_ill;
    logic [CNT_W-1:0] set_cnt_q, reset_cnt_q, illegal_cnt_q;

    // Decode the sampled drive and compute the model's next state.
    // Any encoding other than 10/01/00, X/Z included, falls to the default and is treated as 11.
    always_comb begin
        state_d = state_q;
        exp_q_d = exp_q_q;
        is_set  = 1'b0;
        is_rst  = 1'b0;
        is_ill  = 1'b0;
        case ({mon.S, mon.R})
            2'b10: begin
                is_set  = 1'b1;
                state_d = TRACK;
                exp_q_d = 1'b1;
            end
            2'b01: begin
                is_rst  = 1'b1;
                state_d = TRACK;
                exp_q_d = 1'b0;
            end
            2'b00: begin
                state_d = state_q;
            end
            default: begin
                is_ill  = 1'b1;
                state_d = UNDEF;
            end
        endcase
    end

    // Check the flop's current outputs whenever the model was valid after the last edge.
    // A TRACK state implies the last sample was not 11.
    // Q here is the flop's response to that sample.
    always_comb begin
        mismatch_d = 1'b0;
        if (state_q == TRACK) begin
            mismatch_d = (mon.Q != exp_q_q) || (mon.QBar == mon.Q);
        end
    end

    // Model state and expected Q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNKNOWN;
            exp_q_q <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q_q <= exp_q_d;
        end
    end

    // Registered pulses, each reflecting the sample taken on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
            illegal_q  <= is_ill;
        end
    end

    // Event counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_cnt_q     <= '0;
            reset_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else begin
            if (is_set && (set_cnt_q != '1))     set_cnt_q     <= set_cnt_q + 1'b1;
            if (is_rst && (reset_cnt_q != '1))   reset_cnt_q   <= reset_cnt_q + 1'b1;
            if (is_ill && (illegal_cnt_q != '1)) illegal_cnt_q <= illegal_cnt_q + 1'b1;
        end
    end

`ifdef SR_MON_STICKY_EN
    logic err_sticky_q;

    // Latch any error on the same edge as its pulse, and hold it until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_q <= 1'b0;
        end else if (mismatch_d || is_ill) begin
            err_sticky_q <= 1'b1;
        end
    end

    assign err_sticky = err_sticky_q;
`else
    assign err_sticky = 1'b0;
`endif

    assign exp_q       = exp_q_q;
    assign exp_valid   = (state_q == TRACK);
    assign mismatch    = mismatch_q;
    assign illegal     = illegal_q;
    assign set_cnt     = set_cnt_q;
    assign reset_cnt   = reset_cnt_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_sr_ff_monitor.sv
// tb_sr_ff_monitor: directed test of sr_ff_monitor.
// Two instances watch the same flop: an 8-bit counter build and a 2-bit counter build.
// The 2-bit build exercises saturation.
module tb_sr_ff_monitor;

`ifdef SR_MON_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk;
    logic rst_n;
    sr_ff_monitor_if bus ();

    // behavioural flop with fault overrides on Q and QBar
    logic flop_q;
    logic fq_en, fq_val, fqb_en, fqb_val;

    logic       e8_q, e8_v, mm8, il8, st8;
    logic [7:0] sc8, rc8, ic8;
    logic       e2_q, e2_v, mm2, il2, st2;
    logic [1:0] sc2, rc2, ic2;

    int total;
    int bad;

    sr_ff_monitor #(.CNT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .mon(bus.slave),
        .exp_q(e8_q), .exp_valid(e8_v), .mismatch(mm8), .illegal(il8),
        .set_cnt(sc8), .reset_cnt(rc8), .illegal_cnt(ic8), .err_sticky(st8)
    );

    sr_ff_monitor #(.CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .mon(bus.slave),
        .exp_q(e2_q), .exp_valid(e2_v), .mismatch(mm2), .illegal(il2),
        .set_cnt(sc2), .reset_cnt(rc2), .illegal_cnt(ic2), .err_sticky(st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) flop_q <= 1'b0;
        else if (bus.S && !bus.R) flop_q <= 1'b1;
        else if (!bus.S && bus.R) flop_q <= 1'b0;
    end

    assign bus.Q    = fq_en  ? fq_val  : flop_q;
    assign bus.QBar = fqb_en ? fqb_val : ~bus.Q;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // check both instances; counts given unsaturated, sticky given as "error seen"
    task automatic chk(input string tag, input bit eq, input bit ev, input bit mm,
                       input bit il, input int sc, input int rc, input int ic, input bit st);
        cmp({tag, ".exp_q8"},    32'(e8_q), 32'(eq));
        cmp({tag, ".exp_v8"},    32'(e8_v), 32'(ev));
        cmp({tag, ".mism8"},     32'(mm8),  32'(mm));
        cmp({tag, ".ill8"},      32'(il8),  32'(il));
        cmp({tag, ".setc8"},     32'(sc8),  32'(sc));
        cmp({tag, ".rstc8"},     32'(rc8),  32'(rc));
        cmp({tag, ".illc8"},     32'(ic8),  32'(ic));
        cmp({tag, ".sticky8"},   32'(st8),  32'(st & STICKY));
        cmp({tag, ".exp_q2"},    32'(e2_q), 32'(eq));
        cmp({tag, ".exp_v2"},    32'(e2_v), 32'(ev));
        cmp({tag, ".mism2"},     32'(mm2),  32'(mm));
        cmp({tag, ".ill2"},      32'(il2),  32'(il));
        cmp({tag, ".setc2"},     32'(sc2),  32'(sat3(sc)));
        cmp({tag, ".rstc2"},     32'(rc2),  32'(sat3(rc)));
        cmp({tag, ".illc2"},     32'(ic2),  32'(sat3(ic)));
        cmp({tag, ".sticky2"},   32'(st2),  32'(st & STICKY));
    endtask

    task automatic drive(input logic s, input logic r);
        bus.S = s;
        bus.R = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        fq_en = 1'b0; fq_val = 1'b0; fqb_en = 1'b0; fqb_val = 1'b0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0);

        // reset for 2 cycles, then idle
        tick(); tick();
        chk("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0); tick();
            chk("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        end

        // set then reset against a correct flop
        drive(1'b1, 1'b0); tick(); chk("set",    1, 1, 0, 0, 1, 0, 0, 0);
        drive(1'b0, 1'b0); tick(); chk("hold1",  1, 1, 0, 0, 1, 0, 0, 0);
        drive(1'b0, 1'b1); tick(); chk("rst",    0, 1, 0, 0, 1, 1, 0, 0);
        drive(1'b0, 1'b0); tick(); chk("hold0",  0, 1, 0, 0, 1, 1, 0, 0);

        // forbidden drive, back to back, then recovery
        drive(1'b1, 1'b1); tick(); chk("ill1",   0, 0, 0, 1, 1, 1, 1, 1);
        drive(1'b1, 1'b1); tick(); chk("ill2",   0, 0, 0, 1, 1, 1, 2, 1);
        drive(1'b1, 1'b0); tick(); chk("recov",  1, 1, 0, 0, 2, 1, 2, 1);
        drive(1'b0, 1'b0); tick(); chk("recchk", 1, 1, 0, 0, 2, 1, 2, 1);

        // faulty Q: forced low for one cycle after a set
        drive(1'b1, 1'b0); tick(); chk("set3",   1, 1, 0, 0, 3, 1, 2, 1);
        drive(1'b0, 1'b0);
        fq_en = 1'b1; fq_val = 1'b0;
        tick(); chk("qfault",  1, 1, 1, 0, 3, 1, 2, 1);
        fq_en = 1'b0;
        tick(); chk("qclear",  1, 1, 0, 0, 3, 1, 2, 1);

        // faulty QBar: equal to Q for one cycle
        fqb_en = 1'b1; fqb_val = 1'b1;
        tick(); chk("qbfault", 1, 1, 1, 0, 3, 1, 2, 1);
        fqb_en = 1'b0;
        tick(); chk("qbclear", 1, 1, 0, 0, 3, 1, 2, 1);

        // 8-bit counter moves past 3 while the 2-bit one holds
        drive(1'b1, 1'b0); tick(); chk("set4",   1, 1, 0, 0, 4, 1, 2, 1);
        drive(1'b0, 1'b0);

        // async reset mid-cycle while a mismatch pulse is in flight
        fq_en = 1'b1; fq_val = 1'b0;
        tick(); chk("preRst",  1, 1, 1, 0, 4, 1, 2, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("asyncRst", 0, 0, 0, 0, 0, 0, 0, 0);
        fq_en = 1'b0;
        tick(); tick();
        chk("inRst",   0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // saturation from zero: 6 sets
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b0); tick();
            chk("satSet", 1, 1, 0, 0, i, 0, 0, 0);
        end

        // continuous illegal drive: pulse stays high, counter saturates on 2-bit build
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1); tick();
            chk("satIll", 1, 0, 0, 1, 6, 0, i, 1);
        end
        drive(1'b0, 1'b0); tick();
        chk("illEnd",  1, 0, 0, 0, 6, 0, 4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
